// File: rtl/pe_pkg.sv
// pe_pkg: shared constants for the PE writeback path.
//   DATA_WIDTH / ADDR_WIDTH / NUM_REGS : register file geometry
//   ZERO_REG                           : hard-wired zero register address
//   src_id_e                           : writeback source index encoding
package pe_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = '0;

  typedef enum logic [2:0] {
    SRC_ALU = 3'd0,
    SRC_MUL = 3'd1,
    SRC_LSU = 3'd2
  } src_id_e;

endpackage

// File: rtl/pe_rr_arbiter.sv
// pe_rr_arbiter: combinational round-robin arbiter.
//   req         in  NUM_SRC  request vector
//   ptr         in  IDX_W    highest-priority index this cycle
//   grant       out NUM_SRC  one-hot grant (all zero when no request)
//   grant_idx   out IDX_W    encoded index of the granted request
//   grant_valid out 1        some request was granted
module pe_rr_arbiter #(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  always_comb begin
    int unsigned idx;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    // Scan starting at ptr and wrapping; the first request found wins.
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      idx = (32'(ptr) + i) % NUM_SRC;
      if (!grant_valid && req[IDX_W'(idx)]) begin
        grant_valid             = 1'b1;
        grant[IDX_W'(idx)]      = 1'b1;
        grant_idx               = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/pe_wb_arbiter.sv
// pe_wb_arbiter: round-robin sharing of the register-file write port between
// NUM_SRC writeback sources, registered write, and pending-write scoreboard.
//   clk, rst            clock, asynchronous active-high reset
//   src_valid/src_ready per-source valid/ready handshake
//   src_addr/src_data   flattened per-source address/data (source i at i*W)
//   wr_en/wr_addr/wr_data  registered register-file write (one cycle latency)
//   issue_en/issue_addr issue stage marks a destination as pending
//   chk_addr1/2, busy1/2   operand hazard checks (with same-cycle bypass)
//   issue_busy          issue_addr already pending (WAW)
//   conflict_cnt        cycles with 2+ requesters, saturating; only built
//                       with PE_WB_PERF_CNT_EN defined, otherwise tied to 0
module pe_wb_arbiter
  import pe_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned DATA_WIDTH = pe_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = pe_pkg::ADDR_WIDTH,
  parameter int unsigned NUM_REGS   = pe_pkg::NUM_REGS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC-1:0]             src_valid,
  output logic [NUM_SRC-1:0]             src_ready,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0]  src_addr,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]  src_data,
  output logic                           wr_en,
  output logic [ADDR_WIDTH-1:0]          wr_addr,
  output logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           issue_en,
  input  logic [ADDR_WIDTH-1:0]          issue_addr,
  input  logic [ADDR_WIDTH-1:0]          chk_addr1,
  input  logic [ADDR_WIDTH-1:0]          chk_addr2,
  output logic                           busy1,
  output logic                           busy2,
  output logic                           issue_busy,
  output logic [15:0]                    conflict_cnt
);

  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      grant_idx;
  logic [NUM_SRC-1:0]    grant;
  logic                  grant_valid;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_REGS-1:0]   pend;
  logic [NUM_REGS-1:0]   pend_nxt;

  function automatic logic tracked(input logic [ADDR_WIDTH-1:0] a);
    return (a != ADDR_WIDTH'(ZERO_REG)) && (32'(a) < NUM_REGS);
  endfunction

  // Pending and not being retired by the write on the port this cycle.
  function automatic logic hazard(input logic [NUM_REGS-1:0]   p,
                                  input logic                  we,
                                  input logic [ADDR_WIDTH-1:0] wa,
                                  input logic [ADDR_WIDTH-1:0] a);
    return tracked(a) && p[a] && !(we && (wa == a));
  endfunction

  pe_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req         (src_valid),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign src_ready = rst ? '0 : grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        sel_addr = src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A zero-address grant still consumes the round-robin slot but never writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rr_ptr  <= '0;
    end else begin
      wr_en <= grant_valid && (sel_addr != ADDR_WIDTH'(ZERO_REG));
      if (grant_valid) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
        rr_ptr  <= (grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // Clear first, then set, so an issue on the retiring address stays pending.
  always_comb begin
    pend_nxt = pend;
    if (wr_en && tracked(wr_addr)) begin
      pend_nxt[wr_addr] = 1'b0;
    end
    if (issue_en && tracked(issue_addr)) begin
      pend_nxt[issue_addr] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  assign busy1      = hazard(pend, wr_en, wr_addr, chk_addr1);
  assign busy2      = hazard(pend, wr_en, wr_addr, chk_addr2);
  assign issue_busy = hazard(pend, wr_en, wr_addr, issue_addr);

`ifdef PE_WB_PERF_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (($countones(src_valid) > 1) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: doc/pe_wb_arbiter.md
Name: pe_wb_arbiter

Overview:
Shares the single write port of the PE register file between NUM_SRC writeback sources (e.g. ALU, MUL, LSU) using round-robin arbitration with a valid/ready handshake. Registers the winning write and drives the register file wr_en/wr_addr/wr_data. Holds a pending-write scoreboard so the issue stage can detect RAW/WAW hazards on registers with outstanding writes. Sits between the execution units and the register file.

Parameters:
NUM_SRC, 3, number of writeback requesters (2..8)
DATA_WIDTH, 32, register data width
ADDR_WIDTH, 5, register address width
NUM_REGS, 32, registers tracked by the scoreboard (r0 is hard-wired zero, never tracked)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
src_valid  in  NUM_SRC  per-source write request
src_ready  out  NUM_SRC  per-source grant; handshake completes when valid & ready
src_addr  in  NUM_SRC*ADDR_WIDTH  flattened destination addresses, source i at [i*ADDR_WIDTH +: ADDR_WIDTH]
src_data  in  NUM_SRC*DATA_WIDTH  flattened write data, same packing
wr_en  out  1  to register file write enable
wr_addr  out  ADDR_WIDTH  to register file write address
wr_data  out  DATA_WIDTH  to register file write data
issue_en  in  1  issue stage marks issue_addr as pending write
issue_addr  in  ADDR_WIDTH  destination being issued
chk_addr1  in  ADDR_WIDTH  source operand 1 to check
chk_addr2  in  ADDR_WIDTH  source operand 2 to check
busy1  out  1  chk_addr1 has an outstanding write
busy2  out  1  chk_addr2 has an outstanding write
issue_busy  out  1  issue_addr already pending (WAW hazard)
conflict_cnt  out  16  contention counter (optional feature)

Behaviour:
- Reset: wr_en=0, wr_addr=0, wr_data=0, rr_ptr=0, scoreboard all clear, conflict_cnt=0. src_ready=0 while rst is high. Reset mid-operation discards any registered write; wr_en drops asynchronously.
- Arbitration (combinational): search from rr_ptr upward, wrapping, for the first valid source; assert src_ready only for that source. At most one src_ready is high per cycle. No source valid -> src_ready all 0.
- No backpressure from the register file: a granted source always completes its handshake in that cycle.
- rr_ptr: after a grant to source g, rr_ptr <= (g+1) mod NUM_SRC. No grant -> hold. Wrap at NUM_SRC-1 -> 0.
- Latency: the handshake in cycle N drives wr_en=1 with the captured addr/data in cycle N+1. One write per cycle sustained. wr_en=0 in cycles following no grant.
- Address 0: the request is granted and consumes the round-robin slot, but wr_en stays 0 and the scoreboard is untouched.
- Scoreboard: pend[1..NUM_REGS-1].
  - issue_en with issue_addr != 0 sets the pending bit at the next edge.
  - A registered write (wr_en=1) clears pend[wr_addr] at the next edge.
  - Same edge set and clear on the same address: the set wins.
- busy1/2 = pend[chk_addr] & ~(wr_en & wr_addr==chk_addr); chk_addr 0 -> 0. This matches the register-file same-cycle bypass.
- issue_busy uses the same rule on issue_addr. It is informational only; issue_en while busy leaves the bit set.

Optional Feature:
PE_WB_PERF_CNT_EN
- Defined: conflict_cnt increments in each cycle with two or more src_valid bits set, saturates at 16'hFFFF, and clears on reset.
- Undefined: the counter logic is not compiled and conflict_cnt is tied to 0.

Decomposition:
- Shared package/header pe_pkg: DATA_WIDTH, ADDR_WIDTH, NUM_REGS, ZERO_REG address constant, source-index encoding (SRC_ALU=0, SRC_MUL=1, SRC_LSU=2).
- One sub-module, pe_rr_arbiter: request vector and pointer in, one-hot grant and encoded index out, combinational, parameterised by NUM_SRC.
- Scoreboard and output register stay in the top.

Test Plan:
- Reset: assert rst mid-write (wr_en=1) -> wr_en=0 and busy1/2=0 immediately; after release rr_ptr=0, so with all sources valid, source 0 wins first.
- Round-robin: all three sources valid for 6 cycles with addrs 1/2/3 -> grant order 0,1,2,0,1,2; wr_addr sequence 1,2,3,1,2,3, each one cycle after its grant.
- Single requester: only source 2 valid, addr 7, data 32'hDEADBEEF -> src_ready=3'b100 the same cycle; next cycle wr_en=1, wr_addr=7, wr_data=32'hDEADBEEF.
- Scoreboard: issue r5; chk_addr1=5 -> busy1=1. Source 1 writes r5 -> busy1=0 in the wr_en cycle (bypass) and the pending bit clears after it. Issue r5 in the clear cycle -> busy stays 1.
- Zero register: source 0 writes addr 0 -> src_ready=1, wr_en stays 0, rr_ptr advances to 1. issue r0 -> issue_busy=0 and busy never asserts.
- PE_WB_PERF_CNT_EN defined: 10 cycles with two sources valid -> conflict_cnt=10. Preload the counter near 16'hFFFF -> it saturates at 16'hFFFF. Undefined -> conflict_cnt stays 0.
